// File: rtl/ms_pkg.sv
// Shared constants for the MEM stage; the load_op encodings are also used by the EX-stage decoder.
package ms_pkg;

    localparam int LOAD_OP_W = 3;

    localparam logic [LOAD_OP_W-1:0] LD_W  = 3'd0;
    localparam logic [LOAD_OP_W-1:0] LD_B  = 3'd1;
    localparam logic [LOAD_OP_W-1:0] LD_H  = 3'd2;
    localparam logic [LOAD_OP_W-1:0] LD_BU = 3'd3;
    localparam logic [LOAD_OP_W-1:0] LD_HU = 3'd4;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the byte/half/word out of the read word and extends it.
import ms_pkg::*;

module load_align (
    input  logic [31:0]          rdata,
    input  logic [1:0]           addr,
    input  logic [LOAD_OP_W-1:0] load_op,
    output logic [31:0]          result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        // addr[0] is ignored for halves; misaligned halves never reach this stage.
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (load_op)
            LD_B:    result = {{24{w_byte[7]}}, w_byte};
            LD_BU:   result = {24'd0, w_byte};
            LD_H:    result = {{16{w_half[15]}}, w_half};
            LD_HU:   result = {16'd0, w_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX payload, buffers the SRAM read word, aligns loads, drives WB and ID bypass.
// Build option MS_LOAD_FWD_EN: when defined, load results are bypassed and ms_fwd_stall is tied to 0.
import ms_pkg::*;

module mem_stage (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [31:0]          es_pc,
    input  logic [31:0]          es_alu_result,
    input  logic                 es_res_from_mem,
    input  logic [LOAD_OP_W-1:0] es_load_op,
    input  logic                 es_gr_we,
    input  logic [4:0]           es_dest,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic [31:0]          ms_pc,
    output logic [31:0]          ms_final_result,
    output logic                 ms_gr_we,
    output logic [4:0]           ms_dest,
    output logic                 ms_fwd_valid,
    output logic [4:0]           ms_fwd_dest,
    output logic [31:0]          ms_fwd_data,
    output logic                 ms_fwd_stall
);

    logic                 r_ms_valid;
    logic                 r_ms_first;
    logic [31:0]          r_pc;
    logic [31:0]          r_alu_result;
    logic                 r_res_from_mem;
    logic [LOAD_OP_W-1:0] r_load_op;
    logic                 r_gr_we;
    logic [4:0]           r_dest;
    logic [31:0]          r_rdata_buf;

    logic                 w_accept;
    logic [31:0]          w_rdata;
    logic [31:0]          w_load_result;

    // Handshake: a transfer happens on valid & allowin; MEM always completes in one cycle.
    assign ms_allowin     = !r_ms_valid | ws_allowin;
    assign ms_to_ws_valid = r_ms_valid;
    assign w_accept       = es_to_ms_valid & ms_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ms_valid     <= 1'b0;
            r_ms_first     <= 1'b0;
            r_pc           <= 32'd0;
            r_alu_result   <= 32'd0;
            r_res_from_mem <= 1'b0;
            r_load_op      <= '0;
            r_gr_we        <= 1'b0;
            r_dest         <= 5'd0;
            r_rdata_buf    <= 32'd0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_accept) begin
                r_pc           <= es_pc;
                r_alu_result   <= es_alu_result;
                r_res_from_mem <= es_res_from_mem;
                r_load_op      <= es_load_op;
                r_gr_we        <= es_gr_we;
                r_dest         <= es_dest;
            end
            r_ms_first <= w_accept;
            // SRAM data is only valid in the first MEM cycle; keep it for WB stalls.
            if (r_ms_first) begin
                r_rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign w_rdata = r_ms_first ? data_sram_rdata : r_rdata_buf;

    load_align u_load_align (
        .rdata   (w_rdata),
        .addr    (r_alu_result[1:0]),
        .load_op (r_load_op),
        .result  (w_load_result)
    );

    assign ms_pc           = r_pc;
    assign ms_final_result = r_res_from_mem ? w_load_result : r_alu_result;
    assign ms_gr_we        = r_gr_we;
    assign ms_dest         = r_dest;

    assign ms_fwd_valid = r_ms_valid & r_gr_we & (r_dest != 5'd0);
    assign ms_fwd_dest  = r_dest;
    assign ms_fwd_data  = ms_final_result;

`ifdef MS_LOAD_FWD_EN
    assign ms_fwd_stall = 1'b0;
`else
    assign ms_fwd_stall = ms_fwd_valid & r_res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected results, a negedge monitor pops and compares.
import ms_pkg::*;

module tb_mem_stage;

    localparam int W = 72;

`ifdef MS_LOAD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic        es_res_from_mem;
    logic [2:0]  es_load_op;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ms_fwd_stall;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_pc           (es_pc),
        .es_alu_result   (es_alu_result),
        .es_res_from_mem (es_res_from_mem),
        .es_load_op      (es_load_op),
        .es_gr_we        (es_gr_we),
        .es_dest         (es_dest),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_final_result (ms_final_result),
        .ms_gr_we        (ms_gr_we),
        .ms_dest         (ms_dest),
        .ms_fwd_valid    (ms_fwd_valid),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_data     (ms_fwd_data),
        .ms_fwd_stall    (ms_fwd_stall)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // {pc, result, dest, gr_we, fwd_valid, fwd_stall}
    always @(negedge clk) begin
        if (ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got pc %h, required no output", ms_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pc",        ms_pc,                   mon_e[71:40]);
                check("result",    ms_final_result,         mon_e[39:8]);
                check("dest",      {27'd0, ms_dest},        {27'd0, mon_e[7:3]});
                check("gr_we",     {31'd0, ms_gr_we},       {31'd0, mon_e[2]});
                check("fwd_valid", {31'd0, ms_fwd_valid},   {31'd0, mon_e[1]});
                check("fwd_dest",  {27'd0, ms_fwd_dest},    {27'd0, mon_e[7:3]});
                check("fwd_data",  ms_fwd_data,             mon_e[39:8]);
                check("fwd_stall", {31'd0, ms_fwd_stall},   {31'd0, mon_e[0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 with the instruction in its first MEM cycle.
    task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic rfm,
                        input logic [2:0] op, input logic gr_we, input logic [4:0] dest,
                        input logic [31:0] rdata, input logic [31:0] exp_res);
        logic fv;
        logic st;
        fv = gr_we && (dest != 5'd0);
        st = FWD_EN ? 1'b0 : (fv && rfm);
        es_pc           = pc;
        es_alu_result   = alu;
        es_res_from_mem = rfm;
        es_load_op      = op;
        es_gr_we        = gr_we;
        es_dest         = dest;
        es_to_ms_valid  = 1'b1;
        exp_q.push_back({pc, exp_res, dest, gr_we, fv, st});
        @(negedge clk);
        check("allowin_at_issue", {31'd0, ms_allowin}, 32'd1);
        @(posedge clk);
        #1;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rdata;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0;
        @(posedge clk);
        #1;
        data_sram_rdata = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},     {31'd0, ms_to_ws_valid}, 32'd0);
        check({tag, "_allowin"},   {31'd0, ms_allowin},     32'd1);
        check({tag, "_pc"},        ms_pc,                   32'd0);
        check({tag, "_result"},    ms_final_result,         32'd0);
        check({tag, "_gr_we"},     {31'd0, ms_gr_we},       32'd0);
        check({tag, "_dest"},      {27'd0, ms_dest},        32'd0);
        check({tag, "_fwd_valid"}, {31'd0, ms_fwd_valid},   32'd0);
        check({tag, "_fwd_stall"}, {31'd0, ms_fwd_stall},   32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn          = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_pc           = 32'd0;
        es_alu_result   = 32'd0;
        es_res_from_mem = 1'b0;
        es_load_op      = 3'd0;
        es_gr_we        = 1'b0;
        es_dest         = 5'd0;
        data_sram_rdata = 32'd0;
        ws_allowin      = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Load alignment vectors, each followed by an idle cycle (single-cycle valid pulse).
        send(32'h100, 32'h0000_1003, 1'b1, LD_B,  1'b1, 5'd7, 32'h80FF_1234, 32'hFFFF_FF80); idle();
        send(32'h104, 32'h0000_2002, 1'b1, LD_HU, 1'b1, 5'd8, 32'hBEEF_0001, 32'h0000_BEEF); idle();
        send(32'h108, 32'h0000_2002, 1'b1, LD_H,  1'b1, 5'd9, 32'hBEEF_0001, 32'hFFFF_BEEF); idle();
        send(32'h10C, 32'h0000_1002, 1'b1, LD_BU, 1'b1, 5'd3, 32'h80FF_1234, 32'h0000_00FF); idle();
        send(32'h110, 32'h0000_2001, 1'b1, LD_H,  1'b1, 5'd4, 32'hBEEF_8001, 32'hFFFF_8001); idle();
        send(32'h114, 32'h0000_3001, 1'b1, 3'd7,  1'b1, 5'd6, 32'hCAFE_F00D, 32'hCAFE_F00D); idle();
        send(32'h118, 32'h0000_1000, 1'b1, LD_W,  1'b0, 5'd7, 32'h0BAD_F00D, 32'h0BAD_F00D); idle();

        // ALU instructions: bypass valid only with a non-zero destination.
        send(32'h11C, 32'h0000_0042, 1'b0, LD_W,  1'b1, 5'd5, 32'hFFFF_FFFF, 32'h0000_0042); idle();
        send(32'h120, 32'h0000_0042, 1'b0, LD_W,  1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_0042); idle();

        // WB stall for 3 cycles; the SRAM word changes after the first cycle.
        ws_allowin = 1'b0;
        send(32'h200, 32'h0000_3000, 1'b1, LD_W, 1'b1, 5'd10, 32'h1234_5678, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_allowin", {31'd0, ms_allowin},     32'd0);
            check("stall_valid",   {31'd0, ms_to_ws_valid}, 32'd1);
            check("stall_result",  ms_final_result,         32'h1234_5678);
            @(posedge clk);
            #1;
            data_sram_rdata = 32'hDEAD_DEAD;
        end
        ws_allowin = 1'b1;
        idle();

        // Back-to-back accepts, no bubble.
        send(32'h300, 32'h0000_1000, 1'b1, LD_B,  1'b1, 5'd11, 32'h1122_33F4, 32'hFFFF_FFF4);
        send(32'h304, 32'h0000_0077, 1'b0, LD_W,  1'b1, 5'd12, 32'h0000_0000, 32'h0000_0077);
        send(32'h308, 32'h0000_1006, 1'b1, LD_HU, 1'b1, 5'd13, 32'h9ABC_0000, 32'h0000_9ABC);
        send(32'h30C, 32'h0000_1001, 1'b1, LD_BU, 1'b1, 5'd14, 32'h0000_A500, 32'h0000_00A5);
        idle();

        // Reset asserted with an instruction in MEM and another offered by EX.
        send(32'h400, 32'h0000_0011, 1'b0, LD_W, 1'b1, 5'd1, 32'h0, 32'h0000_0011);
        send(32'h404, 32'h0000_1003, 1'b1, LD_B, 1'b1, 5'd2, 32'h7F00_0000, 32'h0000_007F);
        es_pc           = 32'h408;
        es_alu_result   = 32'h0000_0033;
        es_res_from_mem = 1'b0;
        es_gr_we        = 1'b1;
        es_dest         = 5'd3;
        es_to_ms_valid  = 1'b1;
        resetn          = 1'b0;
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        send(32'h500, 32'h0000_2000, 1'b1, LD_H, 1'b1, 5'd15, 32'h0000_8123, 32'hFFFF_8123);
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
